// File: rtl/iter_shifter.sv
// Iterative shift unit for the execute stage: SLL, SRL, SRA and ROL,
// moving at most STEP bit positions per clock behind valid/ready handshakes.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE,
  // and out_data does not change while out_valid is high.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t             state, state_next;
  logic [WIDTH-1:0]   data, data_next;
  logic [1:0]         op, op_next;
  logic [SHAMT_W-1:0] rem, rem_next;
  logic [SHAMT_W-1:0] k;

  // Bits consumed this step: the smaller of what is left and STEP.
  // When r >= STEP, STEP itself fits in SHAMT_W bits, so the cast is safe.
  function automatic logic [SHAMT_W-1:0] step_amt(input logic [SHAMT_W-1:0] r);
    if (32'(r) < STEP) return r;
    else return SHAMT_W'(STEP);
  endfunction

  // One partial shift by amt (amt <= STEP <= WIDTH). A shift by WIDTH
  // yields zero, so ROL by 0 or by WIDTH both return d unchanged.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0]   d,
                                                input logic [1:0]         sop,
                                                input logic [SHAMT_W-1:0] amt);
    logic [WIDTH-1:0] r;
    case (sop)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = $signed(d) >>> amt;
      default: r = (d << amt) | (d >> (WIDTH - 32'(amt)));
    endcase
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Datapath registers: operand being shifted, latched op and bits remaining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      op   <= '0;
      rem  <= '0;
    end else begin
      data <= data_next;
      op   <= op_next;
      rem  <= rem_next;
    end
  end

  // Next-state and datapath update: first step on accept, then one step per clock.
  always_comb begin
    state_next = state;
    data_next  = data;
    op_next    = op;
    rem_next   = rem;
    k          = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          k          = step_amt(in_shamt);
          data_next  = shift_by(in_data, in_op, k);
          op_next    = in_op;
          rem_next   = in_shamt - k;
          state_next = (rem_next == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        k         = step_amt(rem);
        data_next = shift_by(data, op, k);
        rem_next  = rem - k;
        if (rem_next == '0) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = data;
  assign state_dbg = state;

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Parametrised multi-cycle shift unit for the processor execute stage. It replaces the fixed single-bit left shift with an iterative shifter. The unit supports logical left, logical right, arithmetic right and rotate left. It shifts up to STEP bit positions per clock. It uses valid/ready handshakes on both sides, so the ALU can stall on it like the multiplier/divider.

Parameters:
WIDTH, 32, datapath width in bits (>=2)
SHAMT_W, 5, shift-amount width; shift amounts up to 2^SHAMT_W-1 are legal, including values >= WIDTH
STEP, 1, maximum bit positions shifted per clock (1..WIDTH)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  request present
in_ready  out  1  unit can accept a request
in_data  in  WIDTH  operand
in_shamt  in  SHAMT_W  shift amount
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset: one clock and one reset only. reset_n is asynchronous and active-low. While low it forces state to IDLE, clears data/op/remaining registers, and drives out_valid=0, out_data=0, busy=0, in_ready=1 after release. Reset mid-operation discards the operation with no output.
- State machine: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). There is no overlap of requests.
- out_valid = (state==DONE). out_data is held stable while out_valid=1.
- Accept: a request is accepted on a clock edge where in_valid & in_ready.
  - On that edge: k = min(in_shamt, STEP). Load data = in_data shifted by k per in_op, op = in_op, rem = in_shamt - k.
  - If rem == 0, go to DONE; otherwise go to SHIFT.
- SHIFT: each edge, k = min(rem, STEP). data is shifted by k and rem -= k. When the new rem == 0, go to DONE.
- DONE: hold until out_ready=1 on an edge, then go to IDLE. There is no same-edge re-accept; a new request is accepted at the earliest one cycle after the result handshake.
- Latency: out_valid goes high L = max(1, ceil(shamt/STEP)) cycles after the accepting edge. shamt=0 gives L=1 with out_data = in_data.
- Shift rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with data MSB; the MSB is invariant across steps.
  - ROL moves bits shifted out of the MSB into the LSB.
- Shift amounts >= WIDTH follow the iterative semantics:
  - SLL/SRL give all zeros.
  - SRA gives all sign bits.
  - ROL gives rotate by shamt mod WIDTH.
- Inputs are ignored outside IDLE. in_data, in_shamt and in_op need only be valid on the accepting edge.
- busy = (state != IDLE).
- Arithmetic: rem is SHAMT_W bits, unsigned, and never underflows because k <= rem.

Test Plan:
- SLL, WIDTH=32, STEP=1, in_data=0x00000001, shamt=31 -> out_valid 31 cycles after accept, out_data=0x80000000; in_ready=0 throughout.
- Right shifts of in_data=0x80000000 with shamt=4:
  - SRA -> 0xF8000000.
  - SRL -> 0x08000000.
  - Each result appears after 4 cycles.
- ROL in_data=0x80000001, shamt=1 -> 0x00000003 after 1 cycle. shamt=0 with any op -> out_data=in_data after 1 cycle.
- STEP=4 build, SLL 0x0000000F, shamt=7 -> out_data=0x00000780 after 2 cycles. shamt=31 (SHAMT_W=5) on the same build -> result after 8 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data constant, in_ready=0, and a pending in_valid is not accepted. Raising out_ready -> IDLE next cycle, then the request is accepted.
- Reset: assert reset_n=0 asynchronously mid-SHIFT (SRA, shamt=20, STEP=1, cycle 10) -> out_valid=0, out_data=0, busy=0 immediately. After release, a new SLL 0x1, shamt=2 -> 0x4 with correct latency 2.
